instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 27 ++
 rtl/fetch_buffer.sv | 85 ++++++++
 rtl/instr_fetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// instr_fetch_pkg : shared constants, FSM encodings and entry type for fetch
// Rev 1.0
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// fetch_buffer : DEPTH-entry FIFO of {pc, instr}, flushable, push+pop at full
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_buffer
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  output logic               empty,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  fetch_entry_t          mem_q [DEPTH];
  fetch_entry_t          mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // When full, wr_ptr == rd_ptr: the popped head is read this cycle before the write lands.
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : credit-limited instruction fetch with redirect and stale drain
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] stale_q, stale_d;

  logic             grant;
  logic             rsp_live;
  logic             rsp_stale;
  logic             buf_pop;
  logic             buf_empty;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W:0]   in_flight;
  fetch_entry_t     buf_head;
  fetch_entry_t     push_entry;

  always_comb begin
    in_flight = {1'b0, outstanding_q} + {1'b0, buf_count};
    imem_req  = (state_q == ST_RUN) && (in_flight < (CNT_W + 1)'(DEPTH)) && !redirect;
    grant     = imem_req && imem_gnt;
    // Responses are stale whenever any pre-redirect request is still owed.
    rsp_live  = imem_rvalid && !redirect && (stale_q == '0);
    rsp_stale = imem_rvalid && !redirect && (stale_q != '0);
  end

  always_comb begin
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    state_d       = state_q;
    if (redirect) begin
      outstanding_d = '0;
      stale_d       = stale_q + outstanding_q - CNT_W'(imem_rvalid);
      pc_d          = word_align(redirect_pc);
      rsp_pc_d      = word_align(redirect_pc);
      state_d       = (stale_d != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      case ({grant, rsp_live})
        2'b10:   outstanding_d = outstanding_q + 1'b1;
        2'b01:   outstanding_d = outstanding_q - 1'b1;
        default: outstanding_d = outstanding_q;
      endcase
      if (rsp_stale) begin
        stale_d = stale_q - 1'b1;
      end
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_live) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      case (state_q)
        ST_BOOT:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        ST_DRAIN: state_d = (stale_d == '0) ? ST_RUN : ST_DRAIN;
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC_W;
      rsp_pc_q      <= RESET_PC_W;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  assign push_entry = '{pc: rsp_pc_q, instr: imem_rdata};
  assign buf_pop    = instr_valid && instr_ready;

  fetch_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .push       (rsp_live),
    .push_entry (push_entry),
    .pop        (buf_pop),
    .empty      (buf_empty),
    .count      (buf_count),
    .head       (buf_head)
  );

  assign imem_addr   = pc_q;
  assign instr_valid = !buf_empty && !redirect;
  // With nothing buffered, instr_pc shows the address the next live word will carry.
  assign instr       = buf_empty ? NOP_INSTR : buf_head.instr;
  assign instr_pc    = buf_empty ? rsp_pc_q  : buf_head.pc;
  assign opcode      = instr[6:0];

endmodule

`default_nettype wire
